// File: rtl/serial_shift_tx.sv
// serial_shift_tx: parallel-to-serial feeder for a shift-register receiver.
// Accepts one word per valid/ready handshake and presents it one bit per
// strobe on the receiver's right-shift (sr/ir, LSB first) or left-shift
// (sl/il, MSB first) serial input, then pulses done.
// Optional feature macro: SERIAL_SHIFT_TX_CLEAR_EN -- when defined, a CLEAR
// state pulses cl for one cycle before the first strobe so the receiver
// starts from zero; when undefined, cl is tied low and CLEAR does not exist.
module serial_shift_tx #(
    parameter int WIDTH = 4,
    parameter int DIV   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_dir,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             sr,
    output logic             ir,
    output logic             sl,
    output logic             il,
    output logic             cl,
    output logic             busy,
    output logic             done
);

    localparam int BCW = $clog2(WIDTH + 1);
    localparam int DCW = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [BCW-1:0] BIT_LOAD = BCW'(WIDTH);
    localparam logic [BCW-1:0] BIT_ONE  = BCW'(1);
    localparam logic [DCW-1:0] DIV_LAST = DCW'(DIV - 1);
    localparam logic [DCW-1:0] DIV_ONE  = DCW'(1);

`ifdef SERIAL_SHIFT_TX_CLEAR_EN
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;
`endif

    state_t           state_q,   state_d;
    logic [WIDTH-1:0] shreg_q,   shreg_d;
    logic             dir_q,     dir_d;
    logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [DCW-1:0]   div_cnt_q, div_cnt_d;

    logic accept;
    logic strobe;
    logic last_bit;

    // Word moves toward bit 0: the bit just sent on ir falls off the LSB end.
    function automatic logic [WIDTH-1:0] shift_right(input logic [WIDTH-1:0] v);
        return v >> 1;
    endfunction

    // Word moves toward the MSB: the bit just sent on il falls off the MSB end.
    function automatic logic [WIDTH-1:0] shift_left(input logic [WIDTH-1:0] v);
        return v << 1;
    endfunction

    // A handshake can only complete in IDLE, where in_ready is high.
    assign accept   = (state_q == S_IDLE) && in_valid;
    // One strobe per DIV cycles, starting on the first SHIFT cycle.
    assign strobe   = (state_q == S_SHIFT) && (div_cnt_q == '0);
    // The strobe that sends the final bit of the word.
    assign last_bit = strobe && (bit_cnt_q == BIT_ONE);

    // State register; reset mid-word drops straight back to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: IDLE -> [CLEAR] -> SHIFT -> DONE -> IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
`ifdef SERIAL_SHIFT_TX_CLEAR_EN
                    state_d = S_CLEAR;
`else
                    state_d = S_SHIFT;
`endif
                end
            end
`ifdef SERIAL_SHIFT_TX_CLEAR_EN
            S_CLEAR: state_d = S_SHIFT;
`endif
            S_SHIFT: begin
                if (last_bit) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath registers: shift word, direction and the two counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q   <= '0;
            dir_q     <= 1'b0;
            bit_cnt_q <= '0;
            div_cnt_q <= '0;
        end else begin
            shreg_q   <= shreg_d;
            dir_q     <= dir_d;
            bit_cnt_q <= bit_cnt_d;
            div_cnt_q <= div_cnt_d;
        end
    end

    // Datapath next state: load on acceptance, shift and count on strobes.
    always_comb begin
        shreg_d   = shreg_q;
        dir_d     = dir_q;
        bit_cnt_d = bit_cnt_q;
        div_cnt_d = div_cnt_q;

        if (accept) begin
            shreg_d   = in_data;
            dir_d     = in_dir;
            bit_cnt_d = BIT_LOAD;
            div_cnt_d = '0;
        end else if (state_q == S_SHIFT) begin
            div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : (div_cnt_q + DIV_ONE);
            if (strobe) begin
                shreg_d   = dir_q ? shift_left(shreg_q) : shift_right(shreg_q);
                bit_cnt_d = bit_cnt_q - BIT_ONE;
            end
        end
    end

    // Outputs decoded from registered state only; no input reaches an output.
    always_comb begin
        in_ready = (state_q == S_IDLE);
        busy     = (state_q != S_IDLE);
        done     = (state_q == S_DONE);
        cl       = 1'b0;
        sr       = 1'b0;
        ir       = 1'b0;
        sl       = 1'b0;
        il       = 1'b0;
`ifdef SERIAL_SHIFT_TX_CLEAR_EN
        cl       = (state_q == S_CLEAR);
`endif
        if (strobe) begin
            if (dir_q) begin
                sl = 1'b1;
                il = shreg_q[WIDTH-1];
            end else begin
                sr = 1'b1;
                ir = shreg_q[0];
            end
        end
    end

endmodule

// File: doc/serial_shift_tx.md
# serial_shift_tx

Parallel-to-serial transmitter that feeds a 4-bit shift register from the serial side. It accepts one word per valid/ready handshake and sends it one bit per strobe on the register's right- or left-shift serial input. It raises the matching shift enable (sr or sl) for exactly one clock per bit, so that after WIDTH strobes the receiving register holds the word. It sits between a word-producing controller and the register bank.

## Interface
- WIDTH, 4, bits per word; equals the receiving register width; ≥1
- DIV, 1, clock cycles per transmitted bit; ≥1; DIV=1 gives a strobe every cycle
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_data  in  WIDTH  word to transmit
- in_dir  in  1  0 = right shift (LSB first, drives sr/ir); 1 = left shift (MSB first, drives sl/il)
- in_valid  in  1  word available
- in_ready  out  1  block can accept a word (high only in IDLE)
- sr  out  1  right-shift strobe to the receiver
- ir  out  1  serial bit entering the receiver MSB
- sl  out  1  left-shift strobe to the receiver
- il  out  1  serial bit entering the receiver LSB
- cl  out  1  clear pulse to the receiver (see Configuration)
- busy  out  1  high from the acceptance cycle+1 through the DONE cycle
- done  out  1  one-cycle pulse after the last bit

## Operation
- States: IDLE, CLEAR (only with macro), SHIFT, DONE.
- IDLE: in_ready=1, every other output 0. When in_valid&&in_ready at a rising edge: capture in_data into the internal shift register and in_dir into a direction flop; go to CLEAR if enabled, otherwise SHIFT. Load bit_cnt=WIDTH and div_cnt=0.
- CLEAR: cl=1 for one cycle, then SHIFT.
- SHIFT: a strobe cycle occurs when div_cnt==0. In a strobe cycle:
  - dir=0: sr=1, ir=shreg[0], then shreg shifts right.
  - dir=1: sl=1, il=shreg[WIDTH-1], then shreg shifts left.
  - bit_cnt decrements.
- div_cnt counts 0..DIV-1 and wraps.
- After the strobe that takes bit_cnt to 0, go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- Outside strobe cycles, sr, sl, ir and il are all 0. The unselected direction's strobe and data outputs stay 0 for the whole word.
- in_data and in_dir changes after acceptance have no effect. in_valid is ignored while in_ready=0.
- Only one strobe is ever high at a time. sr and sl are never high together.
- Counter widths: bit_cnt is clog2(WIDTH+1) bits; div_cnt is clog2(DIV) bits, minimum 1.

## Timing
- Reset values: state IDLE, in_ready=1, sr=ir=sl=il=cl=busy=done=0, shreg=0, counters=0.
- Acceptance edge is T0. Without the macro, strobes occur in cycles 1, 1+DIV, …, 1+(WIDTH-1)·DIV. done follows in the cycle after the last strobe. in_ready returns the cycle after done.
- DIV=1, WIDTH=4:
  - Strobes in cycles 1–4, done in cycle 5, in_ready=1 in cycle 6.
  - The next word can be accepted at the end of cycle 6.
- With the macro, every post-acceptance event moves one cycle later (cl in cycle 1).
- All outputs are registered, or decoded from registered state only. There is no combinational path from inputs to outputs.
- Reset asserted mid-word: immediately return to IDLE with reset values on all outputs. No done pulse is produced. The partial word is discarded.

## Configuration
- SERIAL_SHIFT_TX_CLEAR_EN defined:
  - Insert the CLEAR state after acceptance.
  - cl pulses high for one cycle before the first strobe, so the receiver starts from 0.
- Not defined:
  - The CLEAR state does not exist.
  - cl is tied to 0.
  - Timing is as given above without the one-cycle shift.

## Test plan
- WIDTH=4, DIV=1, dir=0, data 4'b1011 → sr=1 in cycles 1–4 with ir=1,1,0,1; done in cycle 5; a model receiver starting at 0 ends at 4'b1011; sl=il=0 throughout.
- dir=1, data 4'b0110 → sl=1 in cycles 1–4 with il=0,1,1,0; receiver ends at 4'b0110; sr=ir=0 throughout.
- DIV=3, dir=0, data 4'b1001 → strobes in cycles 1, 4, 7, 10 with ir=1,0,0,1; all other cycles have sr=0; done in cycle 11.
- in_valid held high with two words 4'hA then 4'h5 (dir=0) → second word accepted at the end of cycle 6; its strobes occur in cycles 7–10; in_ready=0 in cycles 1–5.
- Reset asserted after the second strobe of 4'hF → all outputs 0 and in_ready=1 immediately; no done pulse; a following word transmits normally.
- With SERIAL_SHIFT_TX_CLEAR_EN, receiver preloaded with 4'hF, data 4'h3, dir=1 → cl=1 in cycle 1; sl strobes in cycles 2–5 with il=0,0,1,1; done in cycle 6; receiver ends at 4'h3.
